// File: rtl/neopixel_bit_encoder.sv
// neopixel_bit_encoder
// Takes 24-bit GRB pixel words over a valid/ready handshake and drives the
// single-wire WS2812 waveform, MSB first. Each bit is a fixed TBIT-cycle slot
// whose high time is T1H for a '1' and T0H for a '0'. A frame_end request
// inserts a TLATCH-cycle low period at the next pixel boundary so the LED
// strip latches the frame.

module neopixel_bit_encoder #(
    parameter int T0H    = 20,
    parameter int T1H    = 40,
    parameter int TBIT   = 63,
    parameter int TLATCH = 2500
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        frame_end,
    output logic        serial_out,
    output logic        busy,
    output logic        frame_done
);

    // Counter widths are sized one past the largest value they must hold, so
    // a degenerate parameter such as TLATCH=1 still yields a legal width.
    localparam int CW = $clog2(TBIT + 1);
    localparam int LW = $clog2(TLATCH + 1);

    localparam logic [CW-1:0] CYC_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [LW-1:0] LAT_LAST = LW'(TLATCH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [23:0]     shift_reg;
    logic [23:0]     shift_next;
    logic [4:0]      bit_cnt;
    logic [4:0]      bit_next;
    logic [CW-1:0]   cyc_cnt;
    logic [CW-1:0]   cyc_next;
    logic [LW-1:0]   lat_cnt;
    logic [LW-1:0]   lat_next;
    logic            latch_pend;
    logic            pend_next;
    logic            serial_next;

    logic            bit_end;
    logic            word_end;
    logic            lat_end;
    logic            pend_eff;
    logic            accept;

    // A frame_end arriving in the same cycle as a boundary counts as already
    // pending, so the latch wins over a pixel offered in that very cycle.
    assign pend_eff = latch_pend | frame_end;
    assign bit_end  = (state == SEND) && (cyc_cnt == CYC_LAST);
    assign word_end = bit_end && (bit_cnt == 5'd23);
    assign lat_end  = (state == LATCH) && (lat_cnt == LAT_LAST);
    assign accept   = pix_valid && pix_ready;

    // State register; reset aborts any pixel or latch in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision: a pending latch beats a new pixel at every boundary.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pend_eff) begin
                    state_next = LATCH;
                end else if (accept) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (word_end) begin
                    if (accept) begin
                        state_next = SEND;
                    end else if (pend_eff) begin
                        state_next = LATCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            LATCH: begin
                if (lat_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and status outputs; ready only opens at a pixel boundary.
    always_comb begin
        pix_ready  = 1'b0;
        busy       = (state != IDLE);
        frame_done = lat_end;
        if (reset_n && !pend_eff) begin
            if (state == IDLE) begin
                pix_ready = 1'b1;
            end else if (word_end) begin
                pix_ready = 1'b1;
            end
        end
    end

    // Datapath next values: shifter, bit/cycle counters, latch timer, pending flag.
    always_comb begin
        shift_next = shift_reg;
        bit_next   = bit_cnt;
        cyc_next   = cyc_cnt;
        lat_next   = '0;
        pend_next  = latch_pend;

        if (accept) begin
            shift_next = pix_data;
            bit_next   = 5'd0;
            cyc_next   = '0;
        end else if (state == SEND) begin
            if (word_end) begin
                shift_next = shift_reg << 1;
                bit_next   = 5'd0;
                cyc_next   = '0;
            end else if (bit_end) begin
                shift_next = shift_reg << 1;
                bit_next   = bit_cnt + 5'd1;
                cyc_next   = '0;
            end else begin
                cyc_next   = cyc_cnt + CW'(1);
            end
        end

        if ((state == LATCH) && !lat_end) begin
            lat_next = lat_cnt + LW'(1);
        end

        if (lat_end) begin
            pend_next = 1'b0;
        end else if (frame_end && (state != LATCH)) begin
            pend_next = 1'b1;
        end
    end

    // The line level is computed from the values the counters take next, so
    // the registered output lines up with the cycle count it belongs to and
    // the first high cycle appears right after the accepting edge.
    always_comb begin
        serial_next = 1'b0;
        if (state_next == SEND) begin
            serial_next = (cyc_next < (shift_next[23] ? T1H_C : T0H_C));
        end
    end

    // Datapath registers, including the registered data line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            cyc_cnt    <= '0;
            lat_cnt    <= '0;
            latch_pend <= 1'b0;
            serial_out <= 1'b0;
        end else begin
            shift_reg  <= shift_next;
            bit_cnt    <= bit_next;
            cyc_cnt    <= cyc_next;
            lat_cnt    <= lat_next;
            latch_pend <= pend_next;
            serial_out <= serial_next;
        end
    end

endmodule

// File: tb/tb_neopixel_bit_encoder.sv
// tb_neopixel_bit_encoder
// Directed bench for the NeoPixel bit encoder: waveform shape per bit,
// back-to-back pixels, frame latch behaviour and asynchronous reset abort.

module tb_neopixel_bit_encoder;

    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int TBIT   = 63;
    localparam int TLATCH = 2500;

    logic        clock;
    logic        reset_n;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_end;
    logic        serial_out;
    logic        busy;
    logic        frame_done;

    int n_checks;
    int n_errors;
    int cycle_count;
    int pix_start;
    int first_start;
    int bad;

    neopixel_bit_encoder #(
        .T0H    (T0H),
        .T1H    (T1H),
        .TBIT   (TBIT),
        .TLATCH (TLATCH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .frame_end  (frame_end),
        .serial_out (serial_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter used to time pixel starts.
    always @(posedge clock) begin
        cycle_count <= cycle_count + 1;
    end

    task automatic apply_stimulus(input logic valid, input logic [23:0] data, input logic fe);
        pix_valid = valid;
        pix_data  = data;
        frame_end = fe;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sample one whole pixel, starting at the first cycle after the accepting
    // edge. Optionally presents the next word and pulses frame_end at cycle 10
    // of every bit index set in fe_mask (index 0 = first bit sent).
    task automatic check_pixel(input string tag, input logic [23:0] word,
                               input logic next_valid, input logic [23:0] next_data,
                               input logic [23:0] fe_mask, input logic ready_last);
        int   high_len;
        int   bad_shape;
        int   bad_busy;
        int   bad_ready;
        logic exp_ready;
        bad_busy  = 0;
        bad_ready = 0;
        for (int b = 0; b < 24; b++) begin
            high_len  = word[23-b] ? T1H : T0H;
            bad_shape = 0;
            for (int c = 0; c < TBIT; c++) begin
                @(negedge clock);
                if (b == 0 && c == 0) pix_start = cycle_count;
                if (serial_out !== (c < high_len)) bad_shape++;
                if (busy !== 1'b1) bad_busy++;
                exp_ready = (b == 23 && c == TBIT - 1) ? ready_last : 1'b0;
                if (pix_ready !== exp_ready) bad_ready++;
                if (b == 0 && c == 0) begin
                    pix_valid = next_valid;
                    pix_data  = next_data;
                end
                frame_end = fe_mask[b] && (c == 10);
            end
            check_output($sformatf("%s bit%0d waveform", tag, b), bad_shape, 0);
        end
        check_output($sformatf("%s busy during send", tag), bad_busy, 0);
        check_output($sformatf("%s pix_ready during send", tag), bad_ready, 0);
    endtask

    // Sample a complete latch period starting at its first cycle.
    task automatic check_latch(input string tag);
        int bad_line;
        int bad_done;
        int pulses;
        bad_line = 0;
        bad_done = 0;
        pulses   = 0;
        for (int i = 0; i < TLATCH; i++) begin
            @(negedge clock);
            if (serial_out !== 1'b0 || pix_ready !== 1'b0 || busy !== 1'b1) bad_line++;
            if (frame_done !== (i == TLATCH - 1)) bad_done++;
            if (frame_done === 1'b1) pulses++;
            if (i == 0) frame_end = 1'b0;
        end
        check_output($sformatf("%s line/ready/busy", tag), bad_line, 0);
        check_output($sformatf("%s frame_done timing", tag), bad_done, 0);
        check_output($sformatf("%s frame_done pulses", tag), pulses, 1);
    endtask

    // One IDLE cycle: line low, not busy, no frame_done.
    task automatic check_idle(input string tag, input logic exp_ready);
        @(negedge clock);
        check_output($sformatf("%s idle serial_out", tag), {31'd0, serial_out}, 0);
        check_output($sformatf("%s idle busy", tag), {31'd0, busy}, 0);
        check_output($sformatf("%s idle frame_done", tag), {31'd0, frame_done}, 0);
        check_output($sformatf("%s idle pix_ready", tag), {31'd0, pix_ready}, {31'd0, exp_ready});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        cycle_count = 0;
        pix_start   = 0;
        first_start = 0;
        reset_n     = 1'b0;
        apply_stimulus(1'b0, 24'h0, 1'b0);

        // Reset values while reset_n is held low.
        #1;
        check_output("reset serial_out", {31'd0, serial_out}, 0);
        check_output("reset busy", {31'd0, busy}, 0);
        check_output("reset frame_done", {31'd0, frame_done}, 0);
        check_output("reset pix_ready", {31'd0, pix_ready}, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Test 1: single 24'h800000 pixel.
        $display("[TB] single pixel 800000");
        check_idle("t1 pre", 1'b1);
        apply_stimulus(1'b1, 24'h800000, 1'b0);
        check_pixel("t1", 24'h800000, 1'b0, 24'h0, 24'h0, 1'b1);
        check_idle("t1 post", 1'b1);

        // Test 2: back-to-back FFFFFF then 000000 with no gap.
        $display("[TB] back-to-back pixels");
        apply_stimulus(1'b1, 24'hFFFFFF, 1'b0);
        check_pixel("t2a", 24'hFFFFFF, 1'b1, 24'h000000, 24'h0, 1'b1);
        first_start = pix_start;
        check_pixel("t2b", 24'h000000, 1'b0, 24'h0, 24'h0, 1'b1);
        check_output("t2 pixel spacing", pix_start - first_start, 1512);
        check_idle("t2 post", 1'b1);

        // Test 3: frame_end during bit 5 while the next word waits.
        $display("[TB] frame_end mid-pixel");
        apply_stimulus(1'b1, 24'hA5C3F0, 1'b0);
        check_pixel("t3", 24'hA5C3F0, 1'b1, 24'h123456, 24'h000020, 1'b0);
        check_latch("t3 latch");
        check_idle("t3 after latch", 1'b1);
        check_pixel("t3 next", 24'h123456, 1'b0, 24'h0, 24'h0, 1'b1);
        check_idle("t3 post", 1'b1);

        // Test 4: frame_end in IDLE together with pix_valid.
        $display("[TB] frame_end in idle");
        apply_stimulus(1'b1, 24'h0F0F0F, 1'b1);
        #1;
        check_output("t4 no accept with frame_end", {31'd0, pix_ready}, 0);
        check_latch("t4 latch");
        check_idle("t4 after latch", 1'b1);
        check_pixel("t4 pixel", 24'h0F0F0F, 1'b0, 24'h0, 24'h0, 1'b1);

        // Test 5: asynchronous reset during bit 10.
        $display("[TB] reset mid-pixel");
        check_idle("t5 pre", 1'b1);
        apply_stimulus(1'b1, 24'hFFFFFF, 1'b0);
        for (int i = 0; i <= 10 * TBIT + 5; i++) begin
            @(negedge clock);
            if (i == 0) pix_valid = 1'b0;
        end
        #2;
        check_output("t5 high before reset", {31'd0, serial_out}, 1);
        reset_n = 1'b0;
        #1;
        check_output("t5 async serial_out", {31'd0, serial_out}, 0);
        check_output("t5 async busy", {31'd0, busy}, 0);
        check_output("t5 async pix_ready", {31'd0, pix_ready}, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (serial_out !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b1) bad++;
        end
        check_output("t5 quiet after reset", bad, 0);

        // Test 6: three frame_end pulses in one pixel give one latch.
        $display("[TB] repeated frame_end");
        check_idle("t6 pre", 1'b1);
        apply_stimulus(1'b1, 24'h00FF00, 1'b0);
        check_pixel("t6", 24'h00FF00, 1'b0, 24'h0, 24'h020204, 1'b0);
        check_latch("t6 latch");
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (serial_out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        check_output("t6 no second latch", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
